// File: rtl/arb_pkg.sv
// Shared types and parameter defaults for the instruction/data SRAM arbiter.
package arb_pkg;
   localparam int unsigned DEF_ADDR_W       = 14;
   localparam int unsigned DEF_STARVE_LIMIT = 3;

   typedef enum logic [1:0] {
      R_NONE = 2'd0,
      R_IF   = 2'd1,
      R_DM   = 2'd2
   } resp_owner_e;
endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_cnt
   import arb_pkg::*;
#(
   parameter int unsigned LIMIT = DEF_STARVE_LIMIT,
   parameter int unsigned CNT_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CNT_W'(LIMIT))) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data port: DM priority
// with a bounded fetch starvation window, one access per cycle.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [31:0]       dm_bweb,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_rdata,
   output logic              sram_ceb,
   output logic              sram_web,
   output logic [31:0]       sram_bweb,
   output logic [ADDR_W-1:0] sram_a,
   output logic [31:0]       sram_di,
   input  logic [31:0]       sram_do
);
   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] w_starve_cnt;
   logic             w_starved;
   logic             w_if_gnt;
   logic             w_dm_gnt;
   resp_owner_e      r_owner;

   // Grant decision: DM wins unless the waiting fetch has used up its window
   always_comb begin
      w_starved = if_req && (w_starve_cnt == CNT_W'(STARVE_LIMIT));
      w_dm_gnt  = dm_req && !w_starved;
      w_if_gnt  = if_req && !w_dm_gnt;
   end

   arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
   ) u_starve_cnt (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_inc   (w_dm_gnt && if_req),
      .i_clr   (w_if_gnt || !if_req),
      .o_cnt   (w_starve_cnt)
   );

   always_comb begin
      sram_ceb  = 1'b1;
      sram_web  = 1'b1;
      sram_bweb = '1;
      sram_a    = '0;
      sram_di   = '0;
      if (w_dm_gnt) begin
         sram_ceb = 1'b0;
         sram_web = ~dm_we;
         sram_a   = dm_addr;
         sram_di  = dm_wdata;
         if (dm_we) begin
            sram_bweb = dm_bweb;
         end
      end else if (w_if_gnt) begin
         sram_ceb = 1'b0;
         sram_a   = if_addr;
      end
   end

   // Who owns the read data arriving on sram_do next cycle; writes return nothing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner <= R_NONE;
      end else begin
         case (1'b1)
            w_if_gnt:           r_owner <= R_IF;
            w_dm_gnt && !dm_we: r_owner <= R_DM;
            default:            r_owner <= R_NONE;
         endcase
      end
   end

   assign if_gnt    = w_if_gnt;
   assign dm_gnt    = w_dm_gnt;
   assign if_rvalid = (r_owner == R_IF);
   assign dm_rvalid = (r_owner == R_DM);
   assign if_rdata  = if_rvalid ? sram_do : 32'd0;
   assign dm_rdata  = dm_rvalid ? sram_do : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus held random requests.
module tb_mem_arbiter;
   localparam int unsigned AW  = 14;
   localparam int          LIM = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [31:0]   if_rdata;
   logic          dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0]   dm_bweb = '1, dm_wdata = '0;
   logic [AW-1:0] dm_addr = '0;
   logic          dm_gnt, dm_rvalid;
   logic [31:0]   dm_rdata;
   logic          sram_ceb, sram_web;
   logic [31:0]   sram_bweb, sram_di;
   logic [AW-1:0] sram_a;
   logic [31:0]   sram_do = '0;

   typedef struct {
      bit          is_if;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          m_starve = 0;
   logic [31:0] nxt_do = '0;
   bit          mon_en = 1'b1;

   mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_bweb(dm_bweb), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
      .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every cycle, the response (or its absence) must match the queue head
   always @(negedge clk) begin
      if (mon_en) begin
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            void'(exp_q.pop_front());
            chk("missed_response", 64'(cyc), 64'(0));
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("if_rvalid", 64'(if_rvalid), 64'(e.is_if));
            chk("dm_rvalid", 64'(dm_rvalid), 64'(!e.is_if));
            chk("if_rdata", 64'(if_rdata), e.is_if ? 64'(e.data) : 64'(0));
            chk("dm_rdata", 64'(dm_rdata), e.is_if ? 64'(0) : 64'(e.data));
         end else begin
            chk("idle_rvalid", 64'({if_rvalid, dm_rvalid}), 64'(0));
            chk("idle_rdata", {if_rdata, dm_rdata}, 64'(0));
         end
      end
   end

   // One cycle: apply requests, check grant/SRAM drive against the model, queue any read
   task automatic step(input logic ifr, input logic [AW-1:0] ifa, input logic dmr,
                       input logic we, input logic [31:0] bw, input logic [AW-1:0] dma,
                       input logic [31:0] wd, input logic [31:0] do_next,
                       output logic g_if, output logic g_dm);
      exp_t e;
      @(posedge clk);
      #1;
      sram_do  = nxt_do;
      if_req   = ifr;  if_addr = ifa;
      dm_req   = dmr;  dm_we   = we;  dm_bweb = bw;
      dm_addr  = dma;  dm_wdata = wd;
      #2;
      g_dm = dmr && !(ifr && m_starve == LIM);
      g_if = ifr && !g_dm;
      chk("if_gnt", 64'(if_gnt), 64'(g_if));
      chk("dm_gnt", 64'(dm_gnt), 64'(g_dm));
      chk("sram_ceb", 64'(sram_ceb), 64'(!(g_if || g_dm)));
      chk("sram_web", 64'(sram_web), g_dm ? 64'(!we) : 64'(1));
      chk("sram_bweb", 64'(sram_bweb), (g_dm && we) ? 64'(bw) : 64'(32'hFFFF_FFFF));
      chk("sram_a", 64'(sram_a), g_dm ? 64'(dma) : (g_if ? 64'(ifa) : 64'(0)));
      chk("sram_di", 64'(sram_di), g_dm ? 64'(wd) : 64'(0));
      if (g_if || !ifr) m_starve = 0;
      else if (g_dm && m_starve < LIM) m_starve++;
      nxt_do = do_next;
      if (g_if || (g_dm && !we)) begin
         e.is_if = g_if;
         e.data  = do_next;
         e.due   = cyc + 1;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      logic gi, gd;
      for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '1, '0, '0, $urandom, gi, gd);
   endtask

   initial begin
      logic          gi, gd, p_if, p_dm, r_we;
      logic [AW-1:0] r_ia, r_da;
      logic [31:0]   r_bw, r_wd;
      logic [4:0]    pat;

      // Reset state while held
      #3;
      chk("rst_rvalid", 64'({if_rvalid, dm_rvalid}), 64'(0));
      chk("rst_rdata", {if_rdata, dm_rdata}, 64'(0));
      chk("rst_gnt", 64'({if_gnt, dm_gnt}), 64'(0));
      chk("rst_ceb", 64'(sram_ceb), 64'(1));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // No requests: SRAM idle
      idle(2);

      // Lone fetch, data returned next cycle
      step(1'b1, AW'(16'h0010), 1'b0, 1'b0, '1, '0, '0, 32'hDEAD_BEEF, gi, gd);
      chk("fetch_gnt", 64'(gi), 64'(1));
      idle(1);
      chk("fetch_rvalid", 64'(if_rvalid), 64'(1));
      chk("fetch_rdata", 64'(if_rdata), 64'(32'hDEAD_BEEF));
      idle(1);
      chk("fetch_one_cycle", 64'(if_rvalid), 64'(0));

      // Contention: DM x3, IF, DM
      pat = 5'b10111;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, AW'(16'h0040), 1'b1, 1'b0, '1, AW'(16'h0200), '0, $urandom, gi, gd);
         chk("starve_seq", 64'(gd), 64'(pat[i]));
      end
      idle(2);

      // Masked write, then a full-mask write: no response either time
      step(1'b0, '0, 1'b1, 1'b1, 32'hFFFF_0000, AW'(16'h0004), 32'h1234_5678, $urandom, gi, gd);
      chk("wr_gnt", 64'(gd), 64'(1));
      step(1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFF, AW'(16'h0008), 32'hA5A5_A5A5, $urandom, gi, gd);
      chk("wr_allmask_gnt", 64'(gd), 64'(1));
      idle(2);

      // Back-to-back DM, IF, DM reads
      step(1'b0, '0, 1'b1, 1'b0, '1, AW'(16'h0100), '0, 32'h1111_1111, gi, gd);
      step(1'b1, AW'(16'h0020), 1'b0, 1'b0, '1, '0, '0, 32'h2222_2222, gi, gd);
      step(1'b0, '0, 1'b1, 1'b0, '1, AW'(16'h0104), '0, 32'h3333_3333, gi, gd);
      idle(2);

      // Reset right after a fetch grant drops the pending response
      step(1'b1, AW'(16'h0030), 1'b0, 1'b0, '1, '0, '0, 32'hCAFE_F00D, gi, gd);
      @(posedge clk);
      #1;
      if_req = 1'b0; dm_req = 1'b0;
      rst = 1'b0;
      exp_q.delete();
      m_starve = 0;
      #1;
      chk("rst_drop_rvalid", 64'(if_rvalid), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      idle(3);

      // Random held requests
      p_if = 1'b0; p_dm = 1'b0;
      r_ia = '0; r_da = '0; r_we = 1'b0; r_bw = '1; r_wd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!p_if) begin
            p_if = ($urandom_range(0, 3) != 0);
            r_ia = AW'($urandom);
         end
         if (!p_dm) begin
            p_dm = ($urandom_range(0, 2) != 0);
            r_we = 1'($urandom_range(0, 1));
            r_bw = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            r_da = AW'($urandom);
            r_wd = $urandom;
         end
         step(p_if, r_ia, p_dm, r_we, r_bw, r_da, r_wd, $urandom, gi, gd);
         if (gi) p_if = 1'b0;
         if (gd) p_dm = 1'b0;
      end
      idle(3);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
